// File: rtl/mqnic_tx_req_arbiter_pkg.sv
// Shared definitions for the TX request arbiter: width helpers and
// release-reason encodings reported on the debug output.
package mqnic_tx_arb_pkg;

   // Width of the source-index prefix carried in engine-side tags.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a per-source credit counter able to hold 0..max_out.
   function automatic int credit_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   // Most recent credit-release reason (finish beats start beats dequeue
   // when several land in one cycle).
   localparam logic [1:0] REL_NONE   = 2'd0;
   localparam logic [1:0] REL_DEQ    = 2'd1;
   localparam logic [1:0] REL_START  = 2'd2;
   localparam logic [1:0] REL_FINISH = 2'd3;

endpackage

// File: rtl/mqnic_tx_req_arbiter_if.sv
// Bundle of all request and status signals of the TX request arbiter.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid may not depend on ready, and the payload is
// held stable while valid is high and ready is low.
// Status channels carry no ready and are accepted whenever valid is high.
interface mqnic_tx_req_arbiter_if
   import mqnic_tx_arb_pkg::*;
#(
   parameter int N                 = 4,
   parameter int QUEUE_INDEX_WIDTH = 13,
   parameter int DEST_WIDTH        = 6,
   parameter int REQ_TAG_WIDTH     = 8,
   parameter int SRC_WIDTH         = src_width(N),
   parameter int M_TAG_WIDTH       = REQ_TAG_WIDTH + SRC_WIDTH,
   parameter int DMA_LEN_WIDTH     = 16
);
   logic [N*QUEUE_INDEX_WIDTH-1:0] s_req_queue;
   logic [N*REQ_TAG_WIDTH-1:0]     s_req_tag;
   logic [N*DEST_WIDTH-1:0]        s_req_dest;
   logic [N-1:0]                   s_req_valid;
   logic [N-1:0]                   s_req_ready;

   logic [QUEUE_INDEX_WIDTH-1:0]   m_req_queue;
   logic [M_TAG_WIDTH-1:0]         m_req_tag;
   logic [DEST_WIDTH-1:0]          m_req_dest;
   logic                           m_req_valid;
   logic                           m_req_ready;

   logic                           s_stat_deq_empty;
   logic                           s_stat_deq_error;
   logic [M_TAG_WIDTH-1:0]         s_stat_deq_tag;
   logic                           s_stat_deq_valid;
   logic                           s_stat_start_error;
   logic [DMA_LEN_WIDTH-1:0]       s_stat_start_len;
   logic [M_TAG_WIDTH-1:0]         s_stat_start_tag;
   logic                           s_stat_start_valid;
   logic [DMA_LEN_WIDTH-1:0]       s_stat_finish_len;
   logic [M_TAG_WIDTH-1:0]         s_stat_finish_tag;
   logic                           s_stat_finish_valid;

   logic                           m_stat_deq_empty;
   logic                           m_stat_deq_error;
   logic [REQ_TAG_WIDTH-1:0]       m_stat_deq_tag;
   logic [N-1:0]                   m_stat_deq_valid;
   logic                           m_stat_start_error;
   logic [DMA_LEN_WIDTH-1:0]       m_stat_start_len;
   logic [REQ_TAG_WIDTH-1:0]       m_stat_start_tag;
   logic [N-1:0]                   m_stat_start_valid;
   logic [DMA_LEN_WIDTH-1:0]       m_stat_finish_len;
   logic [REQ_TAG_WIDTH-1:0]       m_stat_finish_tag;
   logic [N-1:0]                   m_stat_finish_valid;

   logic [N-1:0]                   credit_stall;
   logic [1:0]                     dbg_last_release;

   // Arbiter side.
   modport slave (
      input  s_req_queue, s_req_tag, s_req_dest, s_req_valid, m_req_ready,
      input  s_stat_deq_empty, s_stat_deq_error, s_stat_deq_tag, s_stat_deq_valid,
      input  s_stat_start_error, s_stat_start_len, s_stat_start_tag, s_stat_start_valid,
      input  s_stat_finish_len, s_stat_finish_tag, s_stat_finish_valid,
      output s_req_ready, m_req_queue, m_req_tag, m_req_dest, m_req_valid,
      output m_stat_deq_empty, m_stat_deq_error, m_stat_deq_tag, m_stat_deq_valid,
      output m_stat_start_error, m_stat_start_len, m_stat_start_tag, m_stat_start_valid,
      output m_stat_finish_len, m_stat_finish_tag, m_stat_finish_valid,
      output credit_stall, dbg_last_release
   );

   // Environment side (schedulers plus transmit engine).
   modport master (
      output s_req_queue, s_req_tag, s_req_dest, s_req_valid, m_req_ready,
      output s_stat_deq_empty, s_stat_deq_error, s_stat_deq_tag, s_stat_deq_valid,
      output s_stat_start_error, s_stat_start_len, s_stat_start_tag, s_stat_start_valid,
      output s_stat_finish_len, s_stat_finish_tag, s_stat_finish_valid,
      input  s_req_ready, m_req_queue, m_req_tag, m_req_dest, m_req_valid,
      input  m_stat_deq_empty, m_stat_deq_error, m_stat_deq_tag, m_stat_deq_valid,
      input  m_stat_start_error, m_stat_start_len, m_stat_start_tag, m_stat_start_valid,
      input  m_stat_finish_len, m_stat_finish_tag, m_stat_finish_valid,
      input  credit_stall, dbg_last_release
   );
endinterface

// File: rtl/mqnic_tx_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// and moves the pointer one past the winner when advance is strobed.
module mqnic_rr_arbiter #(
   parameter int N  = 4,
   parameter int SW = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic          grant_valid,
   output logic [SW-1:0] grant_index
);
   logic [SW-1:0] ptr;

   // Scan requesters in rotated order starting at the pointer.
   always_comb begin
      logic [SW:0]   sum;
      logic [SW-1:0] idx;
      grant       = '0;
      grant_valid = 1'b0;
      grant_index = '0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (SW+1)'(k);
         if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
         idx = sum[SW-1:0];
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_index = idx;
         end
      end
   end

   // Pointer register: the winner drops to lowest priority next round.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_index == SW'(N-1)) ? '0 : grant_index + SW'(1);
      end
   end
endmodule

// File: rtl/mqnic_tx_req_arbiter.sv
// Shares one transmit engine among N TX schedulers: round-robin request
// arbitration with a per-source outstanding credit limit, and routing of
// engine status back to the source named in the tag MSBs.
// Optional statistics counters: define MQNIC_TX_REQ_ARB_STATS_EN.
module mqnic_tx_req_arbiter
   import mqnic_tx_arb_pkg::*;
#(
   parameter int N                 = 4,
   parameter int QUEUE_INDEX_WIDTH = 13,
   parameter int DEST_WIDTH        = 6,
   parameter int REQ_TAG_WIDTH     = 8,
   parameter int SRC_WIDTH         = src_width(N),
   parameter int M_TAG_WIDTH       = REQ_TAG_WIDTH + SRC_WIDTH,
   parameter int DMA_LEN_WIDTH     = 16,
   parameter int MAX_OUTSTANDING   = 16
)(
   input  logic clk,
   input  logic rst,
   mqnic_tx_req_arbiter_if.slave bus
`ifdef MQNIC_TX_REQ_ARB_STATS_EN
   ,
   output logic [N*32-1:0] stat_grant_count,
   output logic [N*32-1:0] stat_stall_cycles
`endif
);
   localparam int SW = SRC_WIDTH;
   localparam int CW = credit_width(MAX_OUTSTANDING);

   logic           load_allowed;
   logic           advance;
   logic [N-1:0]   elig;
   logic [N-1:0]   grant;
   logic [N-1:0]   grant_inc;
   logic           grant_valid;
   logic [SW-1:0]  grant_index;
   logic [CW-1:0]  credit      [N];
   logic [CW-1:0]  credit_next [N];
   logic [SW-1:0]  deq_src, start_src, fin_src;
   logic [N-1:0]   deq_hit, start_hit, fin_hit;
   logic [N-1:0]   deq_rel, start_rel, fin_rel;

   assign deq_src   = bus.s_stat_deq_tag[M_TAG_WIDTH-1 -: SW];
   assign start_src = bus.s_stat_start_tag[M_TAG_WIDTH-1 -: SW];
   assign fin_src   = bus.s_stat_finish_tag[M_TAG_WIDTH-1 -: SW];

   // Load rule for the single-entry output register, and source eligibility.
   always_comb begin
      load_allowed = !bus.m_req_valid || bus.m_req_ready;
      for (int i = 0; i < N; i++) begin
         elig[i] = bus.s_req_valid[i] && (credit[i] < CW'(MAX_OUTSTANDING));
      end
      advance          = grant_valid && load_allowed;
      grant_inc        = advance ? grant : '0;
      bus.s_req_ready  = grant_inc;
   end

   mqnic_rr_arbiter #(.N(N), .SW(SW)) u_rr (
      .clk         (clk),
      .rst         (rst),
      .req         (elig),
      .advance     (advance),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   // Decode status source; sources at or beyond N match no lane and drop.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         deq_hit[i]   = bus.s_stat_deq_valid    && (deq_src   == SW'(i));
         start_hit[i] = bus.s_stat_start_valid  && (start_src == SW'(i));
         fin_hit[i]   = bus.s_stat_finish_valid && (fin_src   == SW'(i));
         deq_rel[i]   = deq_hit[i] && (bus.s_stat_deq_empty || bus.s_stat_deq_error);
         start_rel[i] = start_hit[i] && bus.s_stat_start_error;
         fin_rel[i]   = fin_hit[i];
      end
   end

   // Next credit: add the grant, subtract all releases, floor at zero.
   always_comb begin
      logic [CW:0] credit_add;
      logic [1:0]  rel_cnt;
      credit_add = '0;
      rel_cnt    = '0;
      for (int i = 0; i < N; i++) begin
         credit_add = {1'b0, credit[i]} + (CW+1)'(grant_inc[i]);
         rel_cnt    = 2'(deq_rel[i]) + 2'(start_rel[i]) + 2'(fin_rel[i]);
         if (credit_add < (CW+1)'(rel_cnt)) credit_next[i] = '0;
         else                               credit_next[i] = CW'(credit_add - (CW+1)'(rel_cnt));
      end
   end

   // Output request register with source prefix on the tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_req_valid <= 1'b0;
         bus.m_req_queue <= '0;
         bus.m_req_tag   <= '0;
         bus.m_req_dest  <= '0;
      end else if (load_allowed) begin
         bus.m_req_valid <= grant_valid;
         if (grant_valid) begin
            bus.m_req_queue <= bus.s_req_queue[grant_index*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
            bus.m_req_tag   <= {grant_index, bus.s_req_tag[grant_index*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]};
            bus.m_req_dest  <= bus.s_req_dest[grant_index*DEST_WIDTH +: DEST_WIDTH];
         end
      end
   end

   // Credit counters and registered stall flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) credit[i] <= '0;
         bus.credit_stall <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            credit[i]           <= credit_next[i];
            bus.credit_stall[i] <= bus.s_req_valid[i] && (credit[i] == CW'(MAX_OUTSTANDING));
         end
      end
   end

   // Status return: three independent one-cycle registered channels.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_stat_deq_valid    <= '0;
         bus.m_stat_deq_empty    <= 1'b0;
         bus.m_stat_deq_error    <= 1'b0;
         bus.m_stat_deq_tag      <= '0;
         bus.m_stat_start_valid  <= '0;
         bus.m_stat_start_error  <= 1'b0;
         bus.m_stat_start_len    <= '0;
         bus.m_stat_start_tag    <= '0;
         bus.m_stat_finish_valid <= '0;
         bus.m_stat_finish_len   <= '0;
         bus.m_stat_finish_tag   <= '0;
      end else begin
         bus.m_stat_deq_valid    <= deq_hit;
         bus.m_stat_start_valid  <= start_hit;
         bus.m_stat_finish_valid <= fin_hit;
         if (|deq_hit) begin
            bus.m_stat_deq_empty <= bus.s_stat_deq_empty;
            bus.m_stat_deq_error <= bus.s_stat_deq_error;
            bus.m_stat_deq_tag   <= bus.s_stat_deq_tag[REQ_TAG_WIDTH-1:0];
         end
         if (|start_hit) begin
            bus.m_stat_start_error <= bus.s_stat_start_error;
            bus.m_stat_start_len   <= bus.s_stat_start_len[DMA_LEN_WIDTH-1:0];
            bus.m_stat_start_tag   <= bus.s_stat_start_tag[REQ_TAG_WIDTH-1:0];
         end
         if (|fin_hit) begin
            bus.m_stat_finish_len <= bus.s_stat_finish_len[DMA_LEN_WIDTH-1:0];
            bus.m_stat_finish_tag <= bus.s_stat_finish_tag[REQ_TAG_WIDTH-1:0];
         end
      end
   end

   // Debug: reason of the latest credit release seen on any source.
   always_ff @(posedge clk) begin
      if (rst)             bus.dbg_last_release <= REL_NONE;
      else if (|fin_rel)   bus.dbg_last_release <= REL_FINISH;
      else if (|start_rel) bus.dbg_last_release <= REL_START;
      else if (|deq_rel)   bus.dbg_last_release <= REL_DEQ;
   end

`ifdef MQNIC_TX_REQ_ARB_STATS_EN
   // Grant counters wrap; stall-cycle counters saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant_count  <= '0;
         stat_stall_cycles <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (grant_inc[i])
               stat_grant_count[i*32 +: 32] <= stat_grant_count[i*32 +: 32] + 32'd1;
            if (bus.credit_stall[i] && (stat_stall_cycles[i*32 +: 32] != 32'hFFFF_FFFF))
               stat_stall_cycles[i*32 +: 32] <= stat_stall_cycles[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/mqnic_tx_req_arbiter.md
Name: mqnic_tx_req_arbiter

Overview:
- Shares one transmit engine between N TX scheduler blocks.
- Round-robin arbitrates their transmit requests onto a single request stream, prefixing each tag with the source index.
- Routes the engine's dequeue/start/finish status back to the originating scheduler with the prefix stripped.
- Enforces a per-source outstanding-request credit limit so one scheduler cannot exhaust the engine's operation table.

Parameters:
- N, 4: number of scheduler sources, 1..16.
- QUEUE_INDEX_WIDTH, 13: queue index width.
- DEST_WIDTH, 6: request dest width.
- REQ_TAG_WIDTH, 8: per-source tag width.
- SRC_WIDTH, (N>1 ? $clog2(N) : 1): source prefix width.
- M_TAG_WIDTH, REQ_TAG_WIDTH+SRC_WIDTH: engine-side tag width; source index occupies the MSBs.
- DMA_LEN_WIDTH, 16: status length width.
- MAX_OUTSTANDING, 16: credit limit per source, at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_req_queue  in  N*QUEUE_INDEX_WIDTH  per-source queue index
- s_req_tag  in  N*REQ_TAG_WIDTH  per-source tag
- s_req_dest  in  N*DEST_WIDTH  per-source dest
- s_req_valid  in  N  per-source request valid
- s_req_ready  out  N  per-source accept
- m_req_queue  out  QUEUE_INDEX_WIDTH  granted queue
- m_req_tag  out  M_TAG_WIDTH  {src, tag}
- m_req_dest  out  DEST_WIDTH  granted dest
- m_req_valid  out  1  request valid
- m_req_ready  in  1  engine accept
- s_stat_deq_empty, s_stat_deq_error  in  1  engine dequeue status flags
- s_stat_deq_tag  in  M_TAG_WIDTH  dequeue tag
- s_stat_deq_valid  in  1  dequeue status valid
- s_stat_start_error  in  1  start status error
- s_stat_start_len  in  DMA_LEN_WIDTH  start length
- s_stat_start_tag  in  M_TAG_WIDTH  start tag
- s_stat_start_valid  in  1  start status valid
- s_stat_finish_len  in  DMA_LEN_WIDTH  finish length
- s_stat_finish_tag  in  M_TAG_WIDTH  finish tag
- s_stat_finish_valid  in  1  finish status valid
- m_stat_deq_empty, m_stat_deq_error  out  1  shared dequeue flags
- m_stat_deq_tag  out  REQ_TAG_WIDTH  stripped dequeue tag
- m_stat_deq_valid  out  N  one-hot dequeue valid
- m_stat_start_error  out  1  shared start error
- m_stat_start_len  out  DMA_LEN_WIDTH  shared start length
- m_stat_start_tag  out  REQ_TAG_WIDTH  stripped start tag
- m_stat_start_valid  out  N  one-hot start valid
- m_stat_finish_len  out  DMA_LEN_WIDTH  shared finish length
- m_stat_finish_tag  out  REQ_TAG_WIDTH  stripped finish tag
- m_stat_finish_valid  out  N  one-hot finish valid
- credit_stall  out  N  source has a request pending but no credit

Behaviour:
- Reset values: all valid outputs, s_req_ready, credit_stall, credit counters and data registers are 0. The round-robin pointer resets to source 0 as highest priority.
- Output register:
  - One entry, holding m_req_*.
  - Load is allowed when the register is empty, or when m_req_valid && m_req_ready in the same cycle (full throughput).
- Eligibility: source i is eligible when s_req_valid[i] is high and credit[i] < MAX_OUTSTANDING.
- Grant:
  - Combinational round-robin among eligible sources, starting at pointer.
  - s_req_ready[i] is high only for the granted source, and only when a load is allowed.
  - On grant the register loads {i, tag}, queue and dest, and m_req_valid rises the next cycle (latency 1).
  - The pointer moves to i+1 mod N.
- Credits:
  - credit[i] is $clog2(MAX_OUTSTANDING+1) bits.
  - +1 on grant to i.
  - -1 per release for i. A release is:
    - deq_valid with (empty or error);
    - start_valid with start_error;
    - finish_valid.
  - Grant and release in the same cycle for the same source give a net change of 0.
  - Multiple releases in one cycle for the same source subtract their count.
  - A release at credit 0 saturates at 0.
- credit_stall[i] is registered: s_req_valid[i] && credit[i]==MAX_OUTSTANDING.
- Status routing:
  - Each of the three channels is registered independently, with latency 1.
  - src = tag[M_TAG_WIDTH-1 -: SRC_WIDTH]. The one-hot valid is set for src, and the tag output is the low REQ_TAG_WIDTH bits.
  - src >= N: the status is dropped, with no valid and no credit change.
- Reset mid-operation: a held request is discarded. Status arriving during reset is ignored.

Optional Feature:
- Macro: MQNIC_TX_REQ_ARB_STATS_EN.
- When defined, adds output stat_grant_count, N*32 bits: per-source free-running grant counters that wrap, reset to 0 and increment on each grant.
- Also adds output stat_stall_cycles, N*32 bits: cycles with credit_stall set, saturating at 32'hFFFFFFFF.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mqnic_tx_arb_pkg holds:
  - the SRC_WIDTH computation function;
  - the credit-width function;
  - localparam release-reason encodings for debug.
- Sub-module mqnic_rr_arbiter: N-wide request vector, one-hot grant, grant-valid, and an advance strobe that updates the pointer.

Test Plan:
- N=4, sources 0..3 all valid continuously, m_req_ready=1 → grants in order 0,1,2,3,0,…, one per cycle. The first m_req_tag equals {2'd0, tag0}.
- Source 1 only, MAX_OUTSTANDING=2, no status → two grants, then s_req_ready[1]=0 and credit_stall[1]=1. One finish with tag {2'd1,x} → a third grant follows within 2 cycles.
- m_req_ready held 0 for 5 cycles with a request waiting → m_req_* stable and all s_req_ready=0. Ready=1 → one accept, and the next grant loads in the same cycle.
- Dequeue status with tag {2'd2, 8'h5A}, empty=1 → m_stat_deq_valid=4'b0100 and m_stat_deq_tag=8'h5A one cycle later, and credit[2] decrements.
- Same-cycle grant to source 3 and finish for source 3 at credit=MAX_OUTSTANDING-1 → credit unchanged.
- N=3, status tag with src=3 → no valid asserted and all credits unchanged.
